// File: rtl/stereo_frame_sequencer_if.sv
// Calc-core handshake bundle: start pulse out, busy and move result back.
interface stereo_frame_sequencer_if #(
    parameter int MOVE_W = 6
) ();

    logic              calc_start;
    logic              calc_busy;
    logic [MOVE_W-1:0] move_in;

    // Sequencer side drives the start pulse and reads busy/result
    modport master (
        output calc_start,
        input  calc_busy,
        input  move_in
    );

    // Calc core side answers the start pulse
    modport slave (
        input  calc_start,
        output calc_busy,
        output move_in
    );

endinterface

// File: rtl/stereo_frame_sequencer.sv
// Stereo depth pipeline sequencer: gates each calc RAM to one whole camera
// frame, starts the disparity core once both frames are in, and holds the
// resulting move value for distance conversion and display.
module stereo_frame_sequencer #(
    parameter int SYNC_TIMEOUT = 2400000,
    parameter int CALC_TIMEOUT = 65535,
    parameter int SETTLE_CYC   = 4,
    parameter int MOVE_W       = 6
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [1:0]               vsync,
    output logic [1:0]               capture_en,
    stereo_frame_sequencer_if.master calc,
    output logic [MOVE_W-1:0]        move_out,
    output logic                     result_valid,
    output logic [7:0]               frame_cnt,
    output logic [1:0]               err,
    output logic [2:0]               state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        SETTLE  = 3'd3,
        START   = 3'd4,
        CALC    = 3'd5,
        LATCH   = 3'd6
    } state_t;

    // Last counter value before a limit is reached (counters start at 0)
    localparam logic [21:0] SYNC_LAST   = 22'(SYNC_TIMEOUT - 1);
    localparam logic [21:0] CALC_LAST   = 22'(CALC_TIMEOUT - 1);
    localparam logic [21:0] SETTLE_LAST = 22'(SETTLE_CYC - 1);

    state_t      st;
    logic [1:0]  vs_meta;
    logic [1:0]  vs_sync;
    logic [1:0]  vs_prev;
    logic [1:0]  prime_cnt;
    logic [1:0]  vs_edge;
    logic [21:0] wait_cnt;
    logic [21:0] wait_inc;
    logic [1:0]  grace_cnt;
    logic        seen_busy;

    // Two-flop synchronizer plus edge history; prime_cnt suppresses edges
    // until the chain has refilled after reset so a vsync held high across
    // reset release does not look like a new frame.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            vs_meta   <= 2'b00;
            vs_sync   <= 2'b00;
            vs_prev   <= 2'b00;
            prime_cnt <= 2'd0;
        end else begin
            vs_meta <= vsync;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
            if (prime_cnt != 2'd3) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

    assign vs_edge  = (prime_cnt == 2'd3) ? (vs_sync & ~vs_prev) : 2'b00;
    assign wait_inc = (wait_cnt == 22'h3FFFFF) ? wait_cnt : wait_cnt + 22'd1;
    assign state    = st;

    // Main sequencer: all outputs are registered and change with the state
    always_ff @(posedge sysclk) begin
        if (reset) begin
            st              <= IDLE;
            capture_en      <= 2'b00;
            calc.calc_start <= 1'b0;
            move_out        <= '0;
            result_valid    <= 1'b0;
            frame_cnt       <= 8'd0;
            err             <= 2'b00;
            wait_cnt        <= 22'd0;
            grace_cnt       <= 2'd0;
            seen_busy       <= 1'b0;
        end else begin
            calc.calc_start <= 1'b0;
            result_valid    <= 1'b0;
            case (st)
                IDLE: begin
                    capture_en <= 2'b00;
                    wait_cnt   <= 22'd0;
                    st         <= ARM;
                end
                ARM: begin
                    if ((capture_en != 2'b00) && (wait_cnt >= SYNC_LAST)) begin
                        capture_en <= 2'b00;
                        err[0]     <= 1'b1;
                        wait_cnt   <= 22'd0;
                    end else if ((capture_en | vs_edge) == 2'b11) begin
                        capture_en <= 2'b11;
                        wait_cnt   <= 22'd0;
                        st         <= CAPTURE;
                    end else begin
                        capture_en <= capture_en | vs_edge;
                        if (capture_en != 2'b00) begin
                            wait_cnt <= wait_inc;
                        end
                    end
                end
                CAPTURE: begin
                    if ((capture_en != 2'b11) && (wait_cnt >= SYNC_LAST)) begin
                        capture_en <= 2'b00;
                        err[0]     <= 1'b1;
                        wait_cnt   <= 22'd0;
                        st         <= ARM;
                    end else if ((capture_en & ~vs_edge) == 2'b00) begin
                        capture_en <= 2'b00;
                        wait_cnt   <= 22'd0;
                        st         <= SETTLE;
                    end else begin
                        capture_en <= capture_en & ~vs_edge;
                        if (capture_en != 2'b11) begin
                            wait_cnt <= wait_inc;
                        end
                    end
                end
                SETTLE: begin
                    capture_en <= 2'b00;
                    if (wait_cnt >= SETTLE_LAST) begin
                        calc.calc_start <= 1'b1;
                        wait_cnt        <= 22'd0;
                        st              <= START;
                    end else begin
                        wait_cnt <= wait_inc;
                    end
                end
                START: begin
                    seen_busy <= 1'b0;
                    grace_cnt <= 2'd0;
                    wait_cnt  <= 22'd0;
                    st        <= CALC;
                end
                CALC: begin
                    if (calc.calc_busy) begin
                        seen_busy <= 1'b1;
                        if (wait_cnt >= CALC_LAST) begin
                            err[1]   <= 1'b1;
                            wait_cnt <= 22'd0;
                            st       <= ARM;
                        end else begin
                            wait_cnt <= wait_inc;
                        end
                    end else if (seen_busy || (grace_cnt == 2'd3)) begin
                        move_out     <= calc.move_in;
                        result_valid <= 1'b1;
                        frame_cnt    <= frame_cnt + 8'd1;
                        err          <= 2'b00;
                        wait_cnt     <= 22'd0;
                        st           <= LATCH;
                    end else begin
                        grace_cnt <= grace_cnt + 2'd1;
                    end
                end
                LATCH: begin
                    wait_cnt <= 22'd0;
                    st       <= ARM;
                end
                default: begin
                    capture_en <= 2'b00;
                    st         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stereo_frame_sequencer.sv
// Scoreboard bench for stereo_frame_sequencer with shortened timeouts.
module tb_stereo_frame_sequencer;

    localparam int MOVE_W = 6;
    localparam int SYNC_T = 1000;
    localparam int CALC_T = 300;
    localparam int SETTLE = 4;

    logic              sysclk = 1'b0;
    logic              reset;
    logic [1:0]        vsync;
    logic [1:0]        capture_en;
    logic [MOVE_W-1:0] move_out;
    logic              result_valid;
    logic [7:0]        frame_cnt;
    logic [1:0]        err;
    logic [2:0]        state;

    int                checks = 0;
    int                errors = 0;
    int                rv_seen = 0;
    logic [MOVE_W-1:0] exp_q[$];
    logic [7:0]        exp_frames;
    logic [MOVE_W-1:0] last_move;

    stereo_frame_sequencer_if #(.MOVE_W(MOVE_W)) cif ();

    stereo_frame_sequencer #(
        .SYNC_TIMEOUT(SYNC_T),
        .CALC_TIMEOUT(CALC_T),
        .SETTLE_CYC  (SETTLE),
        .MOVE_W      (MOVE_W)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .vsync       (vsync),
        .capture_en  (capture_en),
        .calc        (cif),
        .move_out    (move_out),
        .result_valid(result_valid),
        .frame_cnt   (frame_cnt),
        .err         (err),
        .state       (state)
    );

    // Free-running system clock
    always #5 sysclk = ~sysclk;

    task automatic tick();
        @(negedge sysclk);
        if (result_valid === 1'b1) rv_seen++;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        vsync = 2'b00;
        cif.calc_busy = 1'b0;
        cif.move_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        exp_frames = 8'd0;
        last_move = '0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (cif.calc_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cif.calc_start !== 1'b1)
            $display("[TB] FAIL start_wait got %0b expected 1", cif.calc_start);
        if (cif.calc_start !== 1'b1) errors++;
    endtask

    task automatic capture_pair();
        vsync = 2'b11;
        repeat (4) tick();
        vsync = 2'b00;
        repeat (4) tick();
        vsync = 2'b11;
        repeat (4) tick();
        vsync = 2'b00;
        wait_start();
    endtask

    task automatic wait_result();
        int n;
        logic [MOVE_W-1:0] exp_mv;
        n = 0;
        while (result_valid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (result_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL result_wait got %0b expected 1", result_valid);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL result_unexpected got 1 expected 0");
        end else begin
            exp_mv = exp_q.pop_front();
            checks++;
            if (move_out !== exp_mv) begin
                errors++;
                $display("[TB] FAIL move_out got %0d expected %0d", move_out, exp_mv);
            end
            checks++;
            if (frame_cnt !== exp_frames) begin
                errors++;
                $display("[TB] FAIL frame_cnt got %0d expected %0d", frame_cnt, exp_frames);
            end
            last_move = exp_mv;
        end
    endtask

    task automatic do_frame(input logic [MOVE_W-1:0] mv, input int busy_len);
        capture_pair();
        cif.move_in = mv;
        exp_q.push_back(mv);
        exp_frames = exp_frames + 8'd1;
        if (busy_len > 0) begin
            cif.calc_busy = 1'b1;
            repeat (busy_len) tick();
            cif.calc_busy = 1'b0;
        end
        wait_result();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        vsync = 2'b00;
        cif.calc_busy = 1'b0;
        cif.move_in = '0;
        repeat (2) tick();
        checks++;
        if (capture_en !== 2'b00) begin errors++; $display("[TB] FAIL rst_capture_en got %b expected 00", capture_en); end
        checks++;
        if (cif.calc_start !== 1'b0) begin errors++; $display("[TB] FAIL rst_calc_start got %b expected 0", cif.calc_start); end
        checks++;
        if (move_out !== '0) begin errors++; $display("[TB] FAIL rst_move_out got %0d expected 0", move_out); end
        checks++;
        if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_result_valid got %b expected 0", result_valid); end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL rst_frame_cnt got %0d expected 0", frame_cnt); end
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL rst_err got %b expected 00", err); end
        checks++;
        if (state !== 3'd0) begin errors++; $display("[TB] FAIL rst_state got %0d expected 0", state); end
        reset = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        exp_frames = 8'd0;
        last_move = '0;
        checks++;
        if (state !== 3'd1) begin errors++; $display("[TB] FAIL post_rst_state got %0d expected 1", state); end
    endtask

    task automatic test_basic();
        vsync = 2'b11;
        repeat (2) tick();
        checks++;
        if (capture_en !== 2'b00) begin errors++; $display("[TB] FAIL basic_early got %b expected 00", capture_en); end
        tick();
        checks++;
        if (capture_en !== 2'b11) begin errors++; $display("[TB] FAIL basic_arm got %b expected 11", capture_en); end
        checks++;
        if (state !== 3'd2) begin errors++; $display("[TB] FAIL basic_capture_state got %0d expected 2", state); end
        tick();
        vsync = 2'b00;
        repeat (4) tick();
        vsync = 2'b11;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b00) begin errors++; $display("[TB] FAIL basic_done got %b expected 00", capture_en); end
        checks++;
        if (state !== 3'd3) begin errors++; $display("[TB] FAIL basic_settle got %0d expected 3", state); end
        vsync = 2'b00;
        repeat (3) tick();
        checks++;
        if (state !== 3'd3 || cif.calc_start !== 1'b0) begin errors++; $display("[TB] FAIL basic_settle_end got %0d/%b expected 3/0", state, cif.calc_start); end
        tick();
        checks++;
        if (cif.calc_start !== 1'b1 || state !== 3'd4) begin errors++; $display("[TB] FAIL basic_start got %b/%0d expected 1/4", cif.calc_start, state); end
        tick();
        checks++;
        if (cif.calc_start !== 1'b0 || state !== 3'd5) begin errors++; $display("[TB] FAIL basic_start_pulse got %b/%0d expected 0/5", cif.calc_start, state); end
        cif.calc_busy = 1'b1;
        cif.move_in = 6'd23;
        exp_q.push_back(6'd23);
        exp_frames = exp_frames + 8'd1;
        repeat (100) tick();
        cif.calc_busy = 1'b0;
        wait_result();
        checks++;
        if (state !== 3'd6) begin errors++; $display("[TB] FAIL basic_latch got %0d expected 6", state); end
        tick();
        checks++;
        if (result_valid !== 1'b0 || state !== 3'd1) begin errors++; $display("[TB] FAIL basic_rv_pulse got %b/%0d expected 0/1", result_valid, state); end
    endtask

    task automatic test_skewed();
        vsync = 2'b10;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b10) begin errors++; $display("[TB] FAIL skew_left_arm got %b expected 10", capture_en); end
        repeat (5) tick();
        vsync = 2'b00;
        repeat (492) tick();
        vsync = 2'b01;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b11 || state !== 3'd2) begin errors++; $display("[TB] FAIL skew_both_arm got %b/%0d expected 11/2", capture_en, state); end
        repeat (5) tick();
        vsync = 2'b00;
        repeat (5) tick();
        vsync = 2'b10;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b01) begin errors++; $display("[TB] FAIL skew_left_done got %b expected 01", capture_en); end
        repeat (20) tick();
        checks++;
        if (capture_en !== 2'b01 || state !== 3'd2 || cif.calc_start !== 1'b0) begin errors++; $display("[TB] FAIL skew_hold got %b/%0d/%b expected 01/2/0", capture_en, state, cif.calc_start); end
        vsync = 2'b00;
        repeat (5) tick();
        vsync = 2'b01;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b00 || state !== 3'd3) begin errors++; $display("[TB] FAIL skew_done got %b/%0d expected 00/3", capture_en, state); end
        vsync = 2'b00;
        wait_start();
        cif.move_in = 6'd42;
        exp_q.push_back(6'd42);
        exp_frames = exp_frames + 8'd1;
        cif.calc_busy = 1'b1;
        repeat (10) tick();
        cif.calc_busy = 1'b0;
        wait_result();
    endtask

    task automatic test_sync_timeout();
        int n;
        vsync = 2'b10;
        repeat (3) tick();
        checks++;
        if (capture_en !== 2'b10) begin errors++; $display("[TB] FAIL sync_arm got %b expected 10", capture_en); end
        repeat (4) tick();
        vsync = 2'b00;
        repeat (4) tick();
        vsync = 2'b10;
        repeat (4) tick();
        vsync = 2'b00;
        repeat (880) tick();
        checks++;
        if (err !== 2'b00 || capture_en !== 2'b10) begin errors++; $display("[TB] FAIL sync_early got %b/%b expected 00/10", err, capture_en); end
        n = 0;
        while (err !== 2'b01 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (err !== 2'b01) begin errors++; $display("[TB] FAIL sync_err got %b expected 01", err); end
        checks++;
        if (capture_en !== 2'b00 || state !== 3'd1) begin errors++; $display("[TB] FAIL sync_rearm got %b/%0d expected 00/1", capture_en, state); end
        do_frame(6'd17, 5);
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL sync_err_clear got %b expected 00", err); end
    endtask

    task automatic test_calc_timeout();
        int n;
        int rv0;
        capture_pair();
        rv0 = rv_seen;
        cif.move_in = 6'd9;
        cif.calc_busy = 1'b1;
        repeat (250) tick();
        checks++;
        if (err !== 2'b00) begin errors++; $display("[TB] FAIL calc_early got %b expected 00", err); end
        n = 0;
        while (err[1] !== 1'b1 && n < 150) begin
            tick();
            n++;
        end
        checks++;
        if (err !== 2'b10) begin errors++; $display("[TB] FAIL calc_err got %b expected 10", err); end
        checks++;
        if (move_out !== last_move) begin errors++; $display("[TB] FAIL calc_move_hold got %0d expected %0d", move_out, last_move); end
        checks++;
        if (state !== 3'd1) begin errors++; $display("[TB] FAIL calc_rearm got %0d expected 1", state); end
        cif.calc_busy = 1'b0;
        repeat (10) tick();
        checks++;
        if (rv_seen !== rv0) begin errors++; $display("[TB] FAIL calc_no_result got %0d expected %0d", rv_seen - rv0, 0); end
        checks++;
        if (frame_cnt !== exp_frames) begin errors++; $display("[TB] FAIL calc_frame_cnt got %0d expected %0d", frame_cnt, exp_frames); end
    endtask

    task automatic test_reset_in_capture();
        vsync = 2'b11;
        repeat (3) tick();
        checks++;
        if (state !== 3'd2) begin errors++; $display("[TB] FAIL rc_capture got %0d expected 2", state); end
        reset = 1'b1;
        tick();
        checks++;
        if (capture_en !== 2'b00 || state !== 3'd0 || err !== 2'b00) begin errors++; $display("[TB] FAIL rc_abort got %b/%0d/%b expected 00/0/00", capture_en, state, err); end
        checks++;
        if (frame_cnt !== 8'd0 || move_out !== '0 || result_valid !== 1'b0 || cif.calc_start !== 1'b0) begin errors++; $display("[TB] FAIL rc_outputs got %0d/%0d/%b/%b expected 0/0/0/0", frame_cnt, move_out, result_valid, cif.calc_start); end
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (capture_en !== 2'b00 || state !== 3'd1) begin errors++; $display("[TB] FAIL rc_no_edge got %b/%0d expected 00/1", capture_en, state); end
        vsync = 2'b00;
        repeat (4) tick();
        exp_q.delete();
        exp_frames = 8'd0;
        last_move = '0;
    endtask

    task automatic test_wrap();
        int rv0;
        apply_reset();
        rv0 = rv_seen;
        for (int i = 0; i < 256; i++) begin
            do_frame(6'($urandom_range(0, 63)), int'($urandom_range(0, 6)));
        end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_frame_cnt got %0d expected 0", frame_cnt); end
        checks++;
        if (rv_seen - rv0 != 256) begin errors++; $display("[TB] FAIL wrap_rv_count got %0d expected 256", rv_seen - rv0); end
    endtask

    // Scenario sequence
    initial begin
        reset = 1'b1;
        vsync = 2'b00;
        cif.calc_busy = 1'b0;
        cif.move_in = '0;
        exp_frames = 8'd0;
        last_move = '0;
        test_reset();
        test_basic();
        test_skewed();
        test_sync_timeout();
        test_calc_timeout();
        test_reset_in_capture();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
